// File: rtl/avalon_sram_slave_if.sv
// ============================================================================
// avalon_sram_slave_if : Avalon-MM burst bus between ao486 master and SRAM slave
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface avalon_sram_slave_if;
  logic [31:2] avs_address;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [3:0]  avs_burstcount;
  logic        avs_write;
  logic        avs_read;
  logic        avs_waitrequest;
  logic        avs_readdatavalid;
  logic [31:0] avs_readdata;

  modport slave (
    input  avs_address, avs_writedata, avs_byteenable, avs_burstcount,
           avs_write, avs_read,
    output avs_waitrequest, avs_readdatavalid, avs_readdata
  );

  modport master (
    output avs_address, avs_writedata, avs_byteenable, avs_burstcount,
           avs_write, avs_read,
    input  avs_waitrequest, avs_readdatavalid, avs_readdata
  );
endinterface

`default_nettype wire

// File: rtl/avalon_sram_slave.sv
// ============================================================================
// avalon_sram_slave : Avalon-MM burst responder fronting a 1-cycle-latency SRAM
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module avalon_sram_slave #(
  parameter int ADDR_W = 12
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  avalon_sram_slave_if.slave     avs,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [31:0]            mem_writedata,
  output logic [3:0]             mem_byteenable,
  output logic                   mem_write,
  output logic                   mem_read,
  input  wire logic [31:0]       mem_readdata,
  output logic                   protocol_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        rem, rem_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              rdv;
  logic              perr_nxt;
  logic              wr_strobe, rd_strobe;

  logic              oversize;
  logic [3:0]        beats;
  logic [2:0]        first_rem;
  logic [ADDR_W-1:0] cmd_addr;

  // Burstcount 0 means one beat; anything above 8 is clipped to 8.
  assign oversize  = avs.avs_burstcount > 4'd8;
  assign beats     = oversize ? 4'd8 :
                     (avs.avs_burstcount == 4'd0) ? 4'd1 : avs.avs_burstcount;
  assign first_rem = 3'(beats - 4'd1);
  assign cmd_addr  = avs.avs_address[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      rem            <= 3'd0;
      ptr            <= '0;
      rdv            <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state          <= state_nxt;
      rem            <= rem_nxt;
      ptr            <= ptr_nxt;
      rdv            <= mem_read;
      protocol_error <= perr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    rem_nxt        = rem;
    ptr_nxt        = ptr;
    perr_nxt       = protocol_error;
    wr_strobe      = 1'b0;
    rd_strobe      = 1'b0;
    mem_address    = ptr;
    mem_byteenable = avs.avs_byteenable;
    case (state)
      S_IDLE: begin
        if (avs.avs_write) begin
          wr_strobe   = 1'b1;
          mem_address = cmd_addr;
          if (avs.avs_read || oversize) perr_nxt = 1'b1;
          if (beats > 4'd1) begin
            state_nxt = S_WRITE;
            rem_nxt   = first_rem;
            ptr_nxt   = cmd_addr + ADDR_W'(1);
          end
        end else if (avs.avs_read) begin
          rd_strobe      = 1'b1;
          mem_address    = cmd_addr;
          mem_byteenable = 4'hF;
          if (oversize) perr_nxt = 1'b1;
          if (beats > 4'd1) begin
            state_nxt = S_READ;
            rem_nxt   = first_rem;
            ptr_nxt   = cmd_addr + ADDR_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (avs.avs_read) perr_nxt = 1'b1;
        if (avs.avs_write) begin
          wr_strobe = 1'b1;
          ptr_nxt   = ptr + ADDR_W'(1);
          rem_nxt   = rem - 3'd1;
          if (rem == 3'd1) state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        // Master inputs are held off by waitrequest here, so they are not errors.
        rd_strobe      = 1'b1;
        mem_byteenable = 4'hF;
        ptr_nxt        = ptr + ADDR_W'(1);
        rem_nxt        = rem - 3'd1;
        if (rem == 3'd1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are gated by reset so an aborted burst stops on the falling edge of rst_n.
  assign mem_write     = wr_strobe & rst_n;
  assign mem_read      = rd_strobe & rst_n;
  assign mem_writedata = avs.avs_writedata;

  assign avs.avs_waitrequest   = (state == S_READ) | ~rst_n;
  assign avs.avs_readdatavalid = rdv;
  assign avs.avs_readdata      = mem_readdata;

endmodule

`default_nettype wire

// File: tb/tb_avalon_sram_slave.sv
// ============================================================================
// tb_avalon_sram_slave : self-checking bench with SRAM model and reference memory
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_avalon_sram_slave;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  avalon_sram_slave_if bus();

  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_byteenable;
  logic              mem_write;
  logic              mem_read;
  logic [31:0]       mem_readdata;
  logic              protocol_error;

  avalon_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .avs            (bus),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_readdata   (mem_readdata),
    .protocol_error (protocol_error)
  );

  // Backing SRAM with one cycle of read latency.
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    if (mem_write)
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) sram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    if (mem_read) mem_readdata <= sram[mem_address];
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic        s_wreq, s_mw, s_mr, s_rdv;
  logic [ADDR_W-1:0] s_addr;
  logic [3:0]  s_be;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [31:0] baddr;
    logic [3:0]  bc;
    logic [3:0]  be;
    logic [31:0] data;
    logic        e_mw;
    logic        e_mr;
    logic [11:0] e_addr;
    logic [3:0]  e_be;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: sample outputs at the falling edge, score read data, step past the rising edge.
  task automatic cyc();
    @(negedge clk);
    s_wreq = bus.avs_waitrequest;
    s_mw   = mem_write;
    s_mr   = mem_read;
    s_rdv  = bus.avs_readdatavalid;
    s_addr = mem_address;
    s_be   = mem_byteenable;
    if (bus.avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdv_unexpected actual=1 required=0 @%0t", $time);
      end else begin
        chk("readdata", bus.avs_readdata, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int beats_of(input logic [3:0] bc);
    return (bc == 4'd0) ? 1 : (bc > 4'd8) ? 8 : int'(bc);
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a & (DEPTH-1)][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic void model_read(input int a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(a + i) & (DEPTH-1)]);
  endfunction

  task automatic set_cmd(input logic wr, input logic rd, input int a, input logic [3:0] bc,
                         input logic [3:0] be, input logic [31:0] d);
    bus.avs_write      = wr;
    bus.avs_read       = rd;
    bus.avs_address    = {18'($urandom), 12'(a)};
    bus.avs_burstcount = bc;
    bus.avs_byteenable = be;
    bus.avs_writedata  = d;
  endtask

  task automatic bus_idle();
    bus.avs_write = 1'b0;
    bus.avs_read  = 1'b0;
  endtask

  task automatic accept(output bit ok);
    ok = 1'b0;
    for (int g = 0; g < 40; g++) begin
      cyc();
      if (!s_wreq) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=waitrequest_stuck required=accepted @%0t", $time);
    end
  endtask

  task automatic wr_burst(input int a, input logic [3:0] bc, input bit rnd);
    bit ok;
    int n = beats_of(bc);
    logic [31:0] d = $urandom;
    logic [3:0]  be = rnd ? 4'($urandom) : 4'hF;
    set_cmd(1'b1, 1'b0, a, bc, be, d);
    accept(ok);
    if (ok) model_write(a, d, be);
    for (int i = 1; i < n; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        bus.avs_write = 1'b0;
        cyc();
      end
      d  = $urandom;
      be = rnd ? 4'($urandom) : 4'hF;
      set_cmd(1'b1, 1'b0, int'($urandom), 4'($urandom), be, d);
      cyc();
      chk("wr_beat_strobe", {31'd0, s_mw}, 32'd1);
      model_write(a + i, d, be);
    end
    bus_idle();
  endtask

  task automatic rd_burst(input int a, input logic [3:0] bc);
    bit ok;
    set_cmd(1'b0, 1'b1, a, bc, 4'($urandom), $urandom);
    accept(ok);
    if (ok) model_read(a, beats_of(bc));
    bus_idle();
  endtask

  task automatic drain();
    for (int g = 0; g < 40 && exp_q.size() > 0; g++) cyc();
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int cnt;
    vt[0] = '{1'b1, 1'b0, 32'h0000_0010, 4'd1, 4'b0110, 32'hAABB_CCDD, 1'b1, 1'b0, 12'h004, 4'b0110};
    vt[1] = '{1'b0, 1'b1, 32'h0000_0010, 4'd1, 4'b0000, 32'h0,         1'b0, 1'b1, 12'h004, 4'hF};
    vt[2] = '{1'b1, 1'b0, 32'hFFFF_C48C, 4'd0, 4'hF,    32'h1234_5678, 1'b1, 1'b0, 12'h123, 4'hF};
    vt[3] = '{1'b0, 1'b1, 32'h0000_3FFC, 4'd0, 4'h3,    32'h0,         1'b0, 1'b1, 12'hFFF, 4'hF};
    vt[4] = '{1'b1, 1'b0, 32'h1234_0008, 4'd1, 4'b0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 12'h002, 4'b0000};

    // Reset state, with the master already requesting.
    rst_n = 1'b0;
    set_cmd(1'b1, 1'b1, 5, 4'd1, 4'hF, 32'h0);
    @(negedge clk);
    chk("rst_waitrequest", {31'd0, bus.avs_waitrequest}, 32'd1);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_rdv", {31'd0, bus.avs_readdatavalid}, 32'd0);
    chk("rst_perr", {31'd0, protocol_error}, 32'd0);
    bus_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a += 2) wr_burst(a, 4'd2, 1'b0);

    for (int v = 0; v < 5; v++) begin
      set_cmd(vt[v].wr, vt[v].rd, int'(vt[v].baddr[13:2]), vt[v].bc, vt[v].be, vt[v].data);
      bus.avs_address = vt[v].baddr[31:2];
      cyc();
      chk("vec_mem_write", {31'd0, s_mw}, {31'd0, vt[v].e_mw});
      chk("vec_mem_read", {31'd0, s_mr}, {31'd0, vt[v].e_mr});
      chk("vec_mem_address", 32'(s_addr), 32'(vt[v].e_addr));
      chk("vec_byteenable", {28'd0, s_be}, {28'd0, vt[v].e_be});
      chk("vec_waitrequest", {31'd0, s_wreq}, 32'd0);
      if (vt[v].wr) model_write(int'(vt[v].e_addr), vt[v].data, vt[v].be);
      else model_read(int'(vt[v].e_addr), 1);
    end
    bus_idle();
    drain();

    // Two-beat write at dword 3 with a stall between beats.
    set_cmd(1'b1, 1'b0, 3, 4'd2, 4'b1000, 32'h1111_1111);
    cyc();
    chk("wb0_addr", 32'(s_addr), 32'h3);
    chk("wb0_be", {28'd0, s_be}, 32'h8);
    model_write(3, 32'h1111_1111, 4'b1000);
    bus.avs_write = 1'b0;
    cyc();
    chk("stall_no_access", {30'd0, s_mw, s_mr}, 32'd0);
    set_cmd(1'b1, 1'b0, int'($urandom), 4'($urandom), 4'b0111, 32'h2222_2222);
    cyc();
    chk("wb1_write", {31'd0, s_mw}, 32'd1);
    chk("wb1_addr", 32'(s_addr), 32'h4);
    model_write(4, 32'h2222_2222, 4'b0111);
    set_cmd(1'b0, 1'b1, 3, 4'd1, 4'h0, 32'h0);
    cyc();
    chk("idle_after_wr", {30'd0, s_mr, s_wreq}, 32'd2);
    model_read(3, 1);
    bus_idle();

    // Eight-beat code read with a second read accepted in the last data cycle.
    for (int i = 0; i < 8; i++) begin
      set_cmd(1'b1, 1'b0, 32 + i, 4'd1, 4'hF, 32'(i));
      cyc();
      model_write(32 + i, 32'(i), 4'hF);
    end
    set_cmd(1'b0, 1'b1, 32, 4'd8, 4'h0, 32'h0);
    cyc();
    chk("r8_accept", {30'd0, s_mr, s_wreq}, 32'd2);
    model_read(32, 8);
    bus_idle();
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("r8_waitrequest", {31'd0, s_wreq}, 32'd1);
      chk("r8_addr", 32'(s_addr), 32'(32 + i));
      chk("r8_rdv", {31'd0, s_rdv}, 32'd1);
    end
    set_cmd(1'b0, 1'b1, 36, 4'd2, 4'h0, 32'h0);
    cyc();
    chk("b2b_accept", {29'd0, s_mr, s_wreq, s_rdv}, 32'd5);
    model_read(36, 2);
    bus_idle();
    cyc();
    chk("b2b_rdv1", {31'd0, s_rdv}, 32'd1);
    cyc();
    chk("b2b_rdv2", {31'd0, s_rdv}, 32'd1);
    cyc();
    chk("b2b_rdv_end", {31'd0, s_rdv}, 32'd0);

    // Four-beat read wrapping past the top of the SRAM.
    set_cmd(1'b0, 1'b1, DEPTH - 2, 4'd4, 4'h0, 32'h0);
    cyc();
    chk("wrap_addr0", 32'(s_addr), 32'hFFE);
    model_read(DEPTH - 2, 4);
    bus_idle();
    cyc();
    chk("wrap_addr1", 32'(s_addr), 32'hFFF);
    cyc();
    chk("wrap_addr2", 32'(s_addr), 32'h000);
    cyc();
    chk("wrap_addr3", 32'(s_addr), 32'h001);
    drain();

    // Simultaneous read and write in IDLE: the write wins.
    chk("perr_clean", {31'd0, protocol_error}, 32'd0);
    set_cmd(1'b1, 1'b1, 48, 4'd1, 4'hF, 32'h5A5A_A5A5);
    cyc();
    chk("both_high", {30'd0, s_mw, s_mr}, 32'd2);
    model_write(48, 32'h5A5A_A5A5, 4'hF);
    bus_idle();
    cyc();
    chk("both_perr", {31'd0, protocol_error}, 32'd1);

    // Reset asserted during beat 3 of an eight-beat read.
    set_cmd(1'b0, 1'b1, 32, 4'd8, 4'h0, 32'h0);
    cyc();
    model_read(32, 8);
    bus_idle();
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {28'd0, bus.avs_waitrequest, mem_read, mem_write, bus.avs_readdatavalid}, 32'h8);
    exp_q.delete();
    cyc();
    cyc();
    chk("abort_perr_clear", {31'd0, protocol_error}, 32'd0);
    rst_n = 1'b1;
    set_cmd(1'b1, 1'b0, 64, 4'd1, 4'hF, 32'hC0DE_0040);
    cyc();
    chk("post_rst_write", {29'd0, s_wreq, s_mw, s_mr}, 32'd2);
    chk("post_rst_addr", 32'(s_addr), 32'h40);
    model_write(64, 32'hC0DE_0040, 4'hF);
    bus_idle();

    // Oversize read burst is clipped to eight beats.
    set_cmd(1'b0, 1'b1, 32, 4'd12, 4'h0, 32'h0);
    cyc();
    cnt = int'(s_mr);
    model_read(32, 8);
    bus_idle();
    for (int i = 0; i < 11; i++) begin
      cyc();
      cnt += int'(s_mr);
    end
    chk("bc12_beats", 32'(cnt), 32'd8);
    chk("bc12_perr", {31'd0, protocol_error}, 32'd1);
    drain();

    // Random traffic scored against the reference memory.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 0) wr_burst(int'($urandom_range(0, DEPTH-1)), 4'($urandom), 1'b1);
      else rd_burst(int'($urandom_range(0, DEPTH-1)), 4'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
